// File: rtl/systolic_array_if.sv
// Bundle of job-control, operand and result-drain signals for systolic_array.
// slave is the engine side; master is the io-buffer/DMA side.
interface systolic_array_if #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int DW   = 16
);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

  logic                 start;
  logic [7:0]           k_len;
  logic                 busy;
  logic                 in_valid;
  logic                 in_ready;
  logic [ROWS*DW-1:0]   a_vec;
  logic [COLS*DW-1:0]   b_vec;
  logic                 res_valid;
  logic                 res_ready;
  logic [DW-1:0]        res_data;
  logic                 res_sat;
  logic [RW-1:0]        res_row;
  logic [CW-1:0]        res_col;
  logic                 done;

  modport slave (
    input  start, k_len, in_valid, a_vec, b_vec, res_ready,
    output busy, in_ready, res_valid, res_data, res_sat, res_row, res_col, done
  );

  modport master (
    output start, k_len, in_valid, a_vec, b_vec, res_ready,
    input  busy, in_ready, res_valid, res_data, res_sat, res_row, res_col, done
  );
endinterface

// File: rtl/systolic_array.sv
// Output-stationary ROWS x COLS signed MAC systolic array computing C = A x B.
// Operand beats are skewed internally (row r of A by r cycles, column c of B by
// c cycles), accumulated in place, then drained row-major through a scaled,
// saturating result port.
// Optional feature macro: SYSTOLIC_ROUND_EN adds 2^(FRAC-1) before the >>> FRAC
// shift (round half toward +inf); undefined gives a plain floor shift.
module systolic_array #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int DW   = 16,
  parameter int ACCW = 2*DW+8,
  parameter int FRAC = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  systolic_array_if.slave   bus
);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int FW = $clog2(ROWS + COLS) + 1;

  localparam logic [ACCW:0] ONE = 1;
`ifdef SYSTOLIC_ROUND_EN
  localparam logic [ACCW:0] ROUND_ADD = (FRAC > 0) ? (ONE << ((FRAC > 0) ? (FRAC - 1) : 0)) : '0;
`else
  localparam logic [ACCW:0] ROUND_ADD = '0;
`endif

  typedef enum logic [1:0] {IDLE, FEED, FLUSH, DRAIN} state_t;

  state_t            r_state;
  logic [7:0]        r_kLen;
  logic [7:0]        r_beatCnt;
  logic [FW-1:0]     r_flushCnt;
  logic              r_busy;
  logic              r_inReady;
  logic              r_resValid;
  logic [DW-1:0]     r_resData;
  logic              r_resSat;
  logic [RW-1:0]     r_row;
  logic [CW-1:0]     r_col;

  logic              w_beat;
  logic              w_clear;
  logic              w_accept;
  logic              w_lastRes;
  logic [RW-1:0]     w_selRow;
  logic [CW-1:0]     w_selCol;
  logic signed [ACCW-1:0] w_sel;
  logic signed [ACCW:0]   w_rounded;
  logic signed [ACCW:0]   w_shifted;
  logic              w_sat;
  logic [DW-1:0]     w_satData;

  logic [DW-1:0]          w_aTap  [ROWS][COLS];
  logic                   w_aTapV [ROWS][COLS];
  logic [DW-1:0]          w_bTap  [ROWS][COLS];
  logic                   w_bTapV [ROWS][COLS];
  logic signed [ACCW-1:0] w_acc   [ROWS][COLS];

  assign w_beat    = bus.in_valid & r_inReady;
  assign w_clear   = (r_state == IDLE) & bus.start;
  assign w_accept  = r_resValid & bus.res_ready;
  assign w_lastRes = (r_row == RW'(ROWS-1)) && (r_col == CW'(COLS-1));

  // Pick the result to load next: the current index while waiting for the
  // first load, the following row-major index once the current one is taken.
  always_comb begin
    w_selRow = r_row;
    w_selCol = r_col;
    if (w_accept) begin
      if (r_col == CW'(COLS-1)) begin
        w_selCol = '0;
        w_selRow = RW'(r_row + 1'b1);
      end else begin
        w_selCol = CW'(r_col + 1'b1);
      end
    end
  end

  assign w_sel     = w_acc[w_selRow][w_selCol];
  assign w_rounded = {w_sel[ACCW-1], w_sel} + ROUND_ADD;
  assign w_shifted = w_rounded >>> FRAC;
  // The shifted value fits in DW bits only if every bit from DW-1 up is a sign copy.
  assign w_sat     = ~((&w_shifted[ACCW:DW-1]) | ~(|w_shifted[ACCW:DW-1]));
  assign w_satData = w_sat ? (w_shifted[ACCW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}})
                           : w_shifted[DW-1:0];

  // A operand lines: stages below r are the row skew, the rest feed PE(r,c) at tap r+c.
  for (genvar r = 0; r < ROWS; r++) begin : rowGen
    logic [DW-1:0] aLine  [0:r+COLS-1];
    logic          aLineV [0:r+COLS-1];

    // Shift every cycle regardless of handshakes; invalid beats travel as bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int j = 0; j < r + COLS; j++) begin
          aLine[j]  <= '0;
          aLineV[j] <= 1'b0;
        end
      end else begin
        aLine[0]  <= bus.a_vec[r*DW +: DW];
        aLineV[0] <= w_beat;
        for (int j = 1; j < r + COLS; j++) begin
          aLine[j]  <= aLine[j-1];
          aLineV[j] <= aLineV[j-1];
        end
      end
    end

    for (genvar c = 0; c < COLS; c++) begin : tapGen
      assign w_aTap[r][c]  = aLine[r+c];
      assign w_aTapV[r][c] = aLineV[r+c];
    end
  end

  // B operand lines: stages below c are the column skew, the rest feed PE(r,c) at tap c+r.
  for (genvar c = 0; c < COLS; c++) begin : colGen
    logic [DW-1:0] bLine  [0:c+ROWS-1];
    logic          bLineV [0:c+ROWS-1];

    // Same free-running shift as the A lines, moving down the column.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int j = 0; j < c + ROWS; j++) begin
          bLine[j]  <= '0;
          bLineV[j] <= 1'b0;
        end
      end else begin
        bLine[0]  <= bus.b_vec[c*DW +: DW];
        bLineV[0] <= w_beat;
        for (int j = 1; j < c + ROWS; j++) begin
          bLine[j]  <= bLine[j-1];
          bLineV[j] <= bLineV[j-1];
        end
      end
    end

    for (genvar r = 0; r < ROWS; r++) begin : tapGen
      assign w_bTap[r][c]  = bLine[c+r];
      assign w_bTapV[r][c] = bLineV[c+r];
    end
  end

  // Processing elements: each holds its own C entry.
  for (genvar r = 0; r < ROWS; r++) begin : peRow
    for (genvar c = 0; c < COLS; c++) begin : peCol
      logic signed [ACCW-1:0] r_acc;
      logic signed [2*DW-1:0] w_prod;

      assign w_prod = $signed(w_aTap[r][c]) * $signed(w_bTap[r][c]);

      // Clear on job start, otherwise accumulate when both arriving tokens are valid.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_acc <= '0;
        end else if (w_clear) begin
          r_acc <= '0;
        end else if (w_aTapV[r][c] && w_bTapV[r][c]) begin
          r_acc <= r_acc + {{(ACCW-2*DW){w_prod[2*DW-1]}}, w_prod};
        end
      end

      assign w_acc[r][c] = r_acc;
    end
  end

  // Job-control FSM with registered busy/in_ready and the registered drain port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_kLen     <= '0;
      r_beatCnt  <= '0;
      r_flushCnt <= '0;
      r_busy     <= 1'b0;
      r_inReady  <= 1'b0;
      r_resValid <= 1'b0;
      r_resData  <= '0;
      r_resSat   <= 1'b0;
      r_row      <= '0;
      r_col      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_kLen    <= bus.k_len;
            r_beatCnt <= '0;
            r_busy    <= 1'b1;
            r_row     <= '0;
            r_col     <= '0;
            if (bus.k_len == 8'd0) begin
              r_state <= DRAIN;
            end else begin
              r_state   <= FEED;
              r_inReady <= 1'b1;
            end
          end
        end
        FEED: begin
          if (w_beat) begin
            if (r_beatCnt == r_kLen - 8'd1) begin
              r_state    <= FLUSH;
              r_inReady  <= 1'b0;
              r_flushCnt <= '0;
            end else begin
              r_beatCnt <= r_beatCnt + 8'd1;
            end
          end
        end
        FLUSH: begin
          if (r_flushCnt == FW'(ROWS + COLS - 2)) begin
            r_state <= DRAIN;
          end else begin
            r_flushCnt <= r_flushCnt + 1'b1;
          end
        end
        DRAIN: begin
          if (!r_resValid || w_accept) begin
            if (w_accept && w_lastRes) begin
              r_state    <= IDLE;
              r_busy     <= 1'b0;
              r_resValid <= 1'b0;
            end else begin
              r_resValid <= 1'b1;
              r_resData  <= w_satData;
              r_resSat   <= w_sat;
              r_row      <= w_selRow;
              r_col      <= w_selCol;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.in_ready  = r_inReady;
  assign bus.res_valid = r_resValid;
  assign bus.res_data  = r_resData;
  assign bus.res_sat   = r_resSat;
  assign bus.res_row   = r_row;
  assign bus.res_col   = r_col;
  assign bus.done      = w_accept & w_lastRes & (r_state == DRAIN);

endmodule

// File: tb/tb_systolic_array.sv
// Scoreboard bench for systolic_array on a non-square 3x4 grid with FRAC=8.
// Expected results are pushed into a queue when a job is issued; a monitor
// pops and compares on every result handshake.
module tb_systolic_array;
  localparam int ROWS = 3;
  localparam int COLS = 4;
  localparam int DW   = 16;
  localparam int FRAC = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  systolic_array_if #(.ROWS(ROWS), .COLS(COLS), .DW(DW)) bus();

  systolic_array #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .ACCW(2*DW+8), .FRAC(FRAC)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct {
    logic [15:0] data;
    logic        sat;
    int          row;
    int          col;
    logic        last;
  } exp_t;

  exp_t expQ[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int nAccepted = 0;
  int doneCount = 0;
  int aM [ROWS][256];
  int bM [256][COLS];

  // Free-running cycle index; the value read between edges names the current cycle.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void pushExp(input int data, input int sat, input int r, input int c);
    exp_t e;
    e.data = data[15:0];
    e.sat  = sat[0];
    e.row  = r;
    e.col  = c;
    e.last = (r == ROWS-1) && (c == COLS-1);
    expQ.push_back(e);
  endfunction

  // Golden scaling: optional half-up rounding, arithmetic shift, clamp to 16 bits.
  function automatic void pushModel(input int k);
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        longint v = 0;
        for (int i = 0; i < k; i++) v += longint'(aM[r][i]) * longint'(bM[i][c]);
`ifdef SYSTOLIC_ROUND_EN
        v += (64'sd1 <<< (FRAC-1));
`endif
        v = v >>> FRAC;
        if (v > 32767)       pushExp(32767, 1, r, c);
        else if (v < -32768) pushExp(-32768, 1, r, c);
        else                 pushExp(int'(v), 0, r, c);
      end
    end
  endfunction

  // Monitor: compares every accepted result, checks hold-stability under backpressure.
  logic        prevHold = 1'b0;
  logic [15:0] pData;
  logic        pSat;
  logic [1:0]  pRow;
  logic [1:0]  pCol;
  always @(negedge clk) begin
    if (!rst_n) begin
      prevHold = 1'b0;
    end else begin
      if (prevHold) begin
        checkOutput("hold_valid", bus.res_valid, 1);
        checkOutput("hold_data", bus.res_data, pData);
        checkOutput("hold_sat", bus.res_sat, pSat);
        checkOutput("hold_row", bus.res_row, pRow);
        checkOutput("hold_col", bus.res_col, pCol);
      end
      if (bus.res_valid && bus.res_ready) begin
        nAccepted++;
        if (expQ.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_result: got data %0d with no expected entry", bus.res_data);
        end else begin
          exp_t e;
          e = expQ.pop_front();
          checkOutput($sformatf("res_data(%0d,%0d)", e.row, e.col), bus.res_data, e.data);
          checkOutput($sformatf("res_sat(%0d,%0d)", e.row, e.col), bus.res_sat, e.sat);
          checkOutput("res_row", bus.res_row, e.row);
          checkOutput("res_col", bus.res_col, e.col);
          checkOutput("done_at_handshake", bus.done, e.last);
        end
      end else if (bus.done) begin
        total++;
        bad++;
        $display("[TB] FAIL done_without_handshake: got done=1 expected 0");
      end
      if (bus.done) doneCount++;
      prevHold = bus.res_valid && !bus.res_ready;
      pData = bus.res_data;
      pSat  = bus.res_sat;
      pRow  = bus.res_row;
      pCol  = bus.res_col;
    end
  end

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_busy"}, bus.busy, 0);
    checkOutput({tag, "_in_ready"}, bus.in_ready, 0);
    checkOutput({tag, "_res_valid"}, bus.res_valid, 0);
    checkOutput({tag, "_res_data"}, bus.res_data, 0);
    checkOutput({tag, "_res_sat"}, bus.res_sat, 0);
    checkOutput({tag, "_res_row"}, bus.res_row, 0);
    checkOutput({tag, "_res_col"}, bus.res_col, 0);
    checkOutput({tag, "_done"}, bus.done, 0);
  endtask

  task automatic startJob(input int k);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.k_len = k[7:0];
    @(posedge clk); #1;
    bus.start = 1'b0;
    checkOutput("busy_after_start", bus.busy, 1);
    checkOutput("in_ready_after_start", bus.in_ready, (k != 0));
  endtask

  // Start a job and stream k beats; gapMode=1 inserts bubbles, spuriousAt pulses start mid-feed.
  task automatic applyStimulus(input int k, input int gapMode, input int spuriousAt, output int lastCyc);
    int i;
    int guard;
    logic [15:0] v;
    doneCount = 0;
    startJob(k);
    i = 0;
    guard = 0;
    lastCyc = -1;
    while (i < k) begin
      if (guard > 4000) begin
        total++;
        bad++;
        $display("[TB] FAIL feed_timeout: accepted %0d beats expected %0d", i, k);
        break;
      end
      guard++;
      bus.in_valid = (gapMode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
      for (int r = 0; r < ROWS; r++) begin
        v = aM[r][i][15:0];
        bus.a_vec[r*DW +: DW] = v;
      end
      for (int c = 0; c < COLS; c++) begin
        v = bM[i][c][15:0];
        bus.b_vec[c*DW +: DW] = v;
      end
      if (i == spuriousAt) begin
        bus.start = 1'b1;
        bus.k_len = 8'd7;
      end
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) begin
        lastCyc = cyc;
        i++;
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    bus.in_valid = 1'b0;
  endtask

  // Wait for done under a cycle budget; optional 5-cycle stall and junk in_valid outside FEED.
  task automatic drainWait(input int expFirst, input int stallAfter, input int junk);
    int base;
    int stallCnt;
    logic seenValid;
    logic seenDone;
    base = nAccepted;
    stallCnt = 0;
    seenValid = 1'b0;
    seenDone = 1'b0;
    if (junk != 0) begin
      bus.in_valid = 1'b1;
      bus.a_vec = '1;
      bus.b_vec = '1;
    end
    for (int n = 0; n < 3000 && !seenDone; n++) begin
      @(negedge clk);
      if (!seenValid && bus.res_valid) begin
        seenValid = 1'b1;
        if (expFirst >= 0) checkOutput("first_valid_cycle", cyc, expFirst);
      end
      if (bus.done) seenDone = 1'b1;
      @(posedge clk); #1;
      if (stallAfter >= 0 && (nAccepted - base) == stallAfter && stallCnt < 5) begin
        bus.res_ready = 1'b0;
        stallCnt++;
      end else begin
        bus.res_ready = 1'b1;
      end
    end
    bus.in_valid = 1'b0;
    bus.res_ready = 1'b1;
    if (!seenDone) begin
      total++;
      bad++;
      $display("[TB] FAIL drain_timeout: done=0 expected 1 within budget");
    end
    checkOutput("busy_after_done", bus.busy, 0);
    checkOutput("done_count", doneCount, 1);
    checkOutput("queue_empty", expQ.size(), 0);
    expQ.delete();
  endtask

  task automatic loadIdentityJob();
    int aHand [ROWS][COLS];
    aHand = '{'{1, 2, 3, 4}, '{5, 6, 7, 8}, '{-1, -2, -3, -4}};
    for (int r = 0; r < ROWS; r++)
      for (int i = 0; i < COLS; i++) aM[r][i] = aHand[r][i];
    for (int i = 0; i < COLS; i++)
      for (int c = 0; c < COLS; c++) bM[i][c] = (i == c) ? 256 : 0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) pushExp(aHand[r][c], 0, r, c);
  endtask

  initial begin
    int lastCyc;
    int rnd [12];
    bus.start = 1'b0;
    bus.k_len = 8'd0;
    bus.in_valid = 1'b0;
    bus.a_vec = '0;
    bus.b_vec = '0;
    bus.res_ready = 1'b1;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkResetState("reset");
    rst_n = 1'b1;

    // A x (256*I) in Q8 returns A; back-to-back beats, junk in_valid during flush/drain.
    loadIdentityJob();
    applyStimulus(COLS, 0, -1, lastCyc);
    drainWait(lastCyc + ROWS + COLS + 1, -1, 1);

    // Small random operands with bubbles, a spurious start mid-feed and a 5-cycle stall.
    for (int i = 0; i < 3; i++) begin
      for (int r = 0; r < ROWS; r++) aM[r][i] = int'($urandom_range(0, 600)) - 300;
      for (int c = 0; c < COLS; c++) bM[i][c] = int'($urandom_range(0, 600)) - 300;
    end
    pushModel(3);
    applyStimulus(3, 1, 1, lastCyc);
    drainWait(lastCyc + ROWS + COLS + 1, 5, 0);

    // Maximum positive products over K=255 clamp to +32767.
    for (int i = 0; i < 255; i++) begin
      for (int r = 0; r < ROWS; r++) aM[r][i] = 32767;
      for (int c = 0; c < COLS; c++) bM[i][c] = 32767;
    end
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) pushExp(32767, 1, r, c);
    applyStimulus(255, 0, -1, lastCyc);
    drainWait(lastCyc + ROWS + COLS + 1, -1, 0);

    // Most negative A against max B clamps to -32768.
    for (int i = 0; i < 255; i++)
      for (int r = 0; r < ROWS; r++) aM[r][i] = -32768;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) pushExp(-32768, 1, r, c);
    applyStimulus(255, 0, -1, lastCyc);
    drainWait(lastCyc + ROWS + COLS + 1, -1, 0);

    // Single beat a=[3,-3,1], b=[128,128,-128,0]: products +-384 and +-128 in Q8.
`ifdef SYSTOLIC_ROUND_EN
    rnd = '{2, 2, -1, 0, -1, -1, 2, 0, 1, 1, 0, 0};
`else
    rnd = '{1, 1, -2, 0, -2, -2, 1, 0, 0, 0, -1, 0};
`endif
    aM[0][0] = 3;
    aM[1][0] = -3;
    aM[2][0] = 1;
    bM[0][0] = 128;
    bM[0][1] = 128;
    bM[0][2] = -128;
    bM[0][3] = 0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) pushExp(rnd[r*COLS + c], 0, r, c);
    applyStimulus(1, 0, -1, lastCyc);
    drainWait(lastCyc + ROWS + COLS + 1, -1, 0);

    // k_len=0 drains ROWS*COLS zeros straight away.
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) pushExp(0, 0, r, c);
    doneCount = 0;
    startJob(0);
    drainWait(-1, -1, 0);

    // Reset in the middle of FEED aborts the job with no done pulse.
    for (int i = 0; i < COLS; i++)
      for (int r = 0; r < ROWS; r++) aM[r][i] = 100;
    doneCount = 0;
    startJob(COLS);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #2;
    checkResetState("midjob_reset");
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checkOutput("no_done_on_abort", doneCount, 0);

    // The next job after the abort is computed cleanly.
    loadIdentityJob();
    applyStimulus(COLS, 1, -1, lastCyc);
    drainWait(lastCyc + ROWS + COLS + 1, 2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
